// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register, load extension, write-back and forwarding history (optional feature: MEM_WB_FORWARD_EN)
module mem_wb_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_regWrite,
    input  logic        in_memToReg,
    input  logic [2:0]  in_loadType,
    input  logic [1:0]  in_addrLow,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_memData,
    input  logic [4:0]  in_writeRegister,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        fwd0Valid,
    output logic [4:0]  fwd0Reg,
    output logic [31:0] fwd0Data,
    output logic        fwd1Valid,
    output logic [4:0]  fwd1Reg,
    output logic [31:0] fwd1Data,
    output logic [31:0] retired
);

    localparam logic [2:0] LD_BYTE_S = 3'b001;
    localparam logic [2:0] LD_BYTE_U = 3'b010;
    localparam logic [2:0] LD_HALF_S = 3'b011;
    localparam logic [2:0] LD_HALF_U = 3'b100;

    logic        capture;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] result;

    logic        valid_q, valid_d;
    logic        wen_q, wen_d;
    logic        done_q, done_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] retired_q, retired_d;

    // A flush always captures (bubble), even while the stage is stalled.
    assign capture = flush | ~stall;

    // Lane selection and sign/zero extension of the raw memory word; unknown load types fall back to word.
    always_comb begin
        ld_byte = in_memData[7:0];
        case (in_addrLow)
            2'd0: ld_byte = in_memData[7:0];
            2'd1: ld_byte = in_memData[15:8];
            2'd2: ld_byte = in_memData[23:16];
            2'd3: ld_byte = in_memData[31:24];
            default: ld_byte = in_memData[7:0];
        endcase
        ld_half = in_addrLow[1] ? in_memData[31:16] : in_memData[15:0];
        case (in_loadType)
            LD_BYTE_S: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            LD_BYTE_U: ld_ext = {24'd0, ld_byte};
            LD_HALF_S: ld_ext = {{16{ld_half[15]}}, ld_half};
            LD_HALF_U: ld_ext = {16'd0, ld_half};
            default:   ld_ext = in_memData;
        endcase
        result = in_memToReg ? ld_ext : in_aluResult;
    end

    // Next slot contents: new capture clears done; a held slot marks itself done after its first cycle.
    always_comb begin
        valid_d   = valid_q;
        wen_d     = wen_q;
        done_d    = 1'b1;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        retired_d = retired_q;
        if (capture) begin
            valid_d = in_valid & ~flush;
            wen_d   = in_regWrite & in_valid & ~flush & (in_writeRegister != 5'd0);
            done_d  = 1'b0;
            wreg_d  = flush ? 5'd0 : in_writeRegister;
            wdata_d = flush ? 32'd0 : result;
            // The count steps at the edge that presents the slot, so it is visible alongside the write pulse.
            if (in_valid && !flush) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    // Stage register; reset discards any held slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            done_q    <= 1'b1;
            wreg_q    <= 5'd0;
            wdata_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            wen_q     <= wen_d;
            done_q    <= done_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            retired_q <= retired_d;
        end
    end

    assign regWrite      = wen_q & ~done_q;
    assign writeRegister = wreg_q;
    assign writeData     = wdata_q;
    assign retired       = retired_q;

`ifdef MEM_WB_FORWARD_EN
    logic        fwd1_valid_q, fwd1_valid_d;
    logic [4:0]  fwd1_reg_q, fwd1_reg_d;
    logic [31:0] fwd1_data_q, fwd1_data_d;

    // History slot: the outgoing write moves down only when a new slot replaces it.
    always_comb begin
        fwd1_valid_d = fwd1_valid_q;
        fwd1_reg_d   = fwd1_reg_q;
        fwd1_data_d  = fwd1_data_q;
        if (capture && wen_q) begin
            fwd1_valid_d = 1'b1;
            fwd1_reg_d   = wreg_q;
            fwd1_data_d  = wdata_q;
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd1_valid_q <= 1'b0;
            fwd1_reg_q   <= 5'd0;
            fwd1_data_q  <= 32'd0;
        end else begin
            fwd1_valid_q <= fwd1_valid_d;
            fwd1_reg_q   <= fwd1_reg_d;
            fwd1_data_q  <= fwd1_data_d;
        end
    end

    assign fwd0Valid = wen_q;
    assign fwd0Reg   = wreg_q;
    assign fwd0Data  = wdata_q;
    assign fwd1Valid = fwd1_valid_q;
    assign fwd1Reg   = fwd1_reg_q;
    assign fwd1Data  = fwd1_data_q;
`else
    assign fwd0Valid = 1'b0;
    assign fwd0Reg   = 5'd0;
    assign fwd0Data  = 32'd0;
    assign fwd1Valid = 1'b0;
    assign fwd1Reg   = 5'd0;
    assign fwd1Data  = 32'd0;
`endif

    // valid_q is kept for visibility of the held slot; it has no output of its own.
    logic unused_valid;
    assign unused_valid = valid_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - randomized self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_regWrite, in_memToReg;
    logic [2:0]  in_loadType;
    logic [1:0]  in_addrLow;
    logic [31:0] in_aluResult, in_memData;
    logic [4:0]  in_writeRegister;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        fwd0Valid, fwd1Valid;
    logic [4:0]  fwd0Reg, fwd1Reg;
    logic [31:0] fwd0Data, fwd1Data;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;

    // Reference: the slot most recently accepted, whether its one write has been issued, and the write history.
    logic        m_wen, m_bubble, m_written;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] m_ret;
    logic        h_valid;
    logic [4:0]  h_reg;
    logic [31:0] h_data;
    int          write_pulses;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regWrite(in_regWrite), .in_memToReg(in_memToReg),
        .in_loadType(in_loadType), .in_addrLow(in_addrLow),
        .in_aluResult(in_aluResult), .in_memData(in_memData),
        .in_writeRegister(in_writeRegister),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .fwd0Valid(fwd0Valid), .fwd0Reg(fwd0Reg), .fwd0Data(fwd0Data),
        .fwd1Valid(fwd1Valid), .fwd1Reg(fwd1Reg), .fwd1Data(fwd1Data),
        .retired(retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Load value computed with plain shifts and arithmetic sign extension.
    function automatic logic [31:0] ref_ext(input logic [2:0] lt, input logic [1:0] al, input logic [31:0] mem);
        int unsigned b, h, sh;
        sh = 8 * int'(al);
        b = (mem >> sh) & 32'hFF;
        sh = al[1] ? 16 : 0;
        h = (mem >> sh) & 32'hFFFF;
        case (lt)
            3'd1: return (b >= 128) ? b - 256 : b;
            3'd2: return b;
            3'd3: return (h >= 32768) ? h - 65536 : h;
            3'd4: return h;
            default: return mem;
        endcase
    endfunction

    task automatic model_reset();
        m_wen = 0; m_bubble = 0; m_written = 1; m_reg = 0; m_data = 0; m_ret = 0;
        h_valid = 0; h_reg = 0; h_data = 0;
    endtask

    task automatic check_all();
        logic exp_rw;
        exp_rw = m_wen && !m_written;
        check("regWrite", {31'd0, regWrite}, {31'd0, exp_rw});
        check("retired", retired, m_ret);
        if (!m_bubble) begin
            check("writeRegister", {27'd0, writeRegister}, {27'd0, m_reg});
            check("writeData", writeData, m_data);
        end
`ifdef MEM_WB_FORWARD_EN
        check("fwd0Valid", {31'd0, fwd0Valid}, {31'd0, m_wen});
        if (!m_bubble) begin
            check("fwd0Reg", {27'd0, fwd0Reg}, {27'd0, m_reg});
            check("fwd0Data", fwd0Data, m_data);
        end
        check("fwd1Valid", {31'd0, fwd1Valid}, {31'd0, h_valid});
        check("fwd1Reg", {27'd0, fwd1Reg}, {27'd0, h_reg});
        check("fwd1Data", fwd1Data, h_data);
`else
        check("fwd_all_zero", {fwd0Valid, fwd1Valid, 20'd0, fwd0Reg, fwd1Reg},  32'd0);
        check("fwd_data_zero", fwd0Data | fwd1Data, 32'd0);
`endif
        if (regWrite === 1'b1) write_pulses++;
        // The one write of a slot is consumed by the cycle in which it is presented.
        m_written = 1;
    endtask

    // Apply one cycle of inputs, advance the reference by the stage's rules, then compare.
    task automatic apply(input logic r, input logic st, input logic fl, input logic v, input logic rw,
                         input logic m2r, input logic [2:0] lt, input logic [1:0] al,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] wr);
        reset = r; stall = st; flush = fl; in_valid = v; in_regWrite = rw; in_memToReg = m2r;
        in_loadType = lt; in_addrLow = al; in_aluResult = alu; in_memData = mem; in_writeRegister = wr;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (fl || !st) begin
            if (m_wen) begin
                h_valid = 1; h_reg = m_reg; h_data = m_data;
            end
            m_bubble  = fl;
            m_wen     = v && rw && !fl && (wr != 0);
            m_written = 0;
            m_reg     = wr;
            m_data    = m2r ? ref_ext(lt, al, mem) : alu;
            if (v && !fl) m_ret = m_ret + 1;
        end
        check_all();
    endtask

    task automatic alu_op(input logic [4:0] wr, input logic [31:0] val);
        apply(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, val, $urandom, wr);
    endtask

    task automatic load_op(input logic [4:0] wr, input logic [2:0] lt, input logic [1:0] al, input logic [31:0] mem);
        apply(0, 0, 0, 1, 1, 1, lt, al, $urandom, mem, wr);
    endtask

    task automatic hold();
        apply(0, 1, 0, $urandom_range(0, 1), 1, 0, 3'd0, 2'd0, $urandom, $urandom, 5'($urandom));
    endtask

    initial begin
        int p0;
        model_reset();
        write_pulses = 0;
        apply(1, 1, 1, 1, 1, 0, 3'd0, 2'd0, 32'hDEAD, 32'hBEEF, 5'd3);
        check("reset_retired", retired, 32'd0);

        alu_op(5'd8, 32'h0000002A);
        check("tp_alu_rw", {31'd0, regWrite}, 32'd1);
        check("tp_alu_data", writeData, 32'h0000002A);
        check("tp_alu_ret", retired, 32'd1);

        load_op(5'd4, 3'd1, 2'd2, 32'h12AB34CD);
        check("tp_lb", writeData, 32'hFFFFFFAB);
        load_op(5'd4, 3'd2, 2'd2, 32'h12AB34CD);
        check("tp_lbu", writeData, 32'h000000AB);
        load_op(5'd4, 3'd3, 2'd1, 32'h12AB34CD);
        check("tp_lh", writeData, 32'h000034CD);
        load_op(5'd4, 3'd4, 2'd3, 32'h9A5634CD);
        check("tp_lhu_hi", writeData, 32'h00009A56);
        load_op(5'd4, 3'd6, 2'd1, 32'h9A5634CD);
        check("tp_ld_word_alias", writeData, 32'h9A5634CD);

        alu_op(5'd0, 32'h1234);
        check("tp_r0_rw", {31'd0, regWrite}, 32'd0);

        p0 = write_pulses;
        alu_op(5'd9, 32'h99);
        hold(); hold(); hold();
        check("tp_stall_one_write", write_pulses - p0, 32'd1);

        alu_op(5'd10, 32'd5);
        alu_op(5'd11, 32'd7);

        apply(0, 1, 1, 1, 1, 0, 3'd0, 2'd0, 32'h12, 32'h0, 5'd12);
        check("tp_flush_rw", {31'd0, regWrite}, 32'd0);
        alu_op(5'd13, 32'h13);
        hold();
        apply(1, 1, 0, 1, 1, 0, 3'd0, 2'd0, 32'h55, 32'h0, 5'd14);
        check("tp_reset_stall_data", writeData, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic r, st, fl;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 10);
            apply(r, st, fl, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

MEM/WB pipeline register and write-back stage of the pipelined MIPS core. Captures the memory-stage result and selects ALU result or load data, with byte/half load extension. Drives the register file write port (`regWrite`, `writeRegister`, `writeData`) and an optional forwarding history toward the EX-stage bypass muxes. Also maintains a retired-instruction counter.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold stage contents; no capture this edge.
- `flush`  in  1  capture a bubble instead of the inputs; has priority over `stall`.
- `in_valid`  in  1  incoming MEM-stage slot holds a real instruction.
- `in_regWrite`  in  1  instruction writes a register.
- `in_memToReg`  in  1  1 = load data, 0 = ALU result.
- `in_loadType`  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101–111 treated as word.
- `in_addrLow`  in  2  low two bits of the load address.
- `in_aluResult`  in  32  ALU result.
- `in_memData`  in  32  raw data-memory word.
- `in_writeRegister`  in  5  destination register.
- `regWrite`  out  1  register file write enable.
- `writeRegister`  out  5  register file write address.
- `writeData`  out  32  register file write data.
- `fwd0Valid` / `fwd0Reg` / `fwd0Data`  out  1/5/32  write currently held in the stage.
- `fwd1Valid` / `fwd1Reg` / `fwd1Data`  out  1/5/32  most recent previously retired write.
- `retired`  out  32  count of retired valid instructions.

## Operation
- Capture edge (`!stall` or `flush`): stage loads `valid = in_valid & !flush`, `wen = in_regWrite & in_valid & !flush & (in_writeRegister != 0)`, destination, and the computed result.
- Result: `in_memToReg ? ext(in_memData) : in_aluResult`, computed before the register (combinational in MEM, registered here).
- Lane numbering little-endian: byte lane n = `in_memData[8n+7:8n]`, n = `in_addrLow`. Half lane = `in_addrLow[1]`; `in_addrLow[0]` ignored for halves (no misalignment detection). Signed types sign-extend bit 7/15; unsigned zero-extend.
- `in_memToReg = 0` ignores `in_loadType`/`in_addrLow`.
- Write pulse: `regWrite = wen & !done`. Internal `done` clears on each capture and sets after the first cycle the slot is presented. A stalled slot writes exactly once.
- Writes to register 0 never assert `regWrite`.
- `writeRegister`/`writeData` always reflect the held slot, including when `regWrite = 0`.
- `retired` increments by 1 on the cycle a valid slot is first presented (same cycle as its write pulse, also for non-writing instructions). Wraps 0xFFFFFFFF -> 0.
- Forwarding:
  - `fwd0*` = held slot; `fwd0Valid = wen`. Stays valid through stalls.
  - On each capture, if the outgoing slot had `wen`, it is shifted into `fwd1*`; otherwise `fwd1*` is kept.
  - Covers the register file's write-then-read window.

## Timing
- Latency: inputs captured at edge N appear on all outputs after edge N; `regWrite` pulse in cycle N+1.
- Back-to-back captures: one write per cycle, no gaps.
- `stall` with `flush` low: outputs, `done`, `fwd1*` unchanged except `done` setting.
- `flush`: next cycle is a bubble (`regWrite = 0`, `fwd0Valid = 0`, no `retired` increment). `fwd1*` still receives the outgoing slot if it had `wen`.
- Reset values (one edge with `reset = 1`, overrides stall/flush): `valid = wen = 0`, `done = 1`, `regWrite = 0`, `writeRegister = 0`, `writeData = 0`, all `fwd*` zero, `retired = 0`.
- Reset mid-stall discards the held slot; an unwritten result is lost.

## Configuration
- `MEM_WB_FORWARD_EN` defined: `fwd0*` and `fwd1*` behave as above.
- Not defined:
  - All `fwd*` outputs tied to 0.
  - `fwd1` history registers not instantiated.
  - Write-back, `regWrite`, and `retired` unchanged.

## Test plan
- Reset, then ALU op to $t0 (reg 8), result 0x0000002A -> next cycle `regWrite = 1`, `writeRegister = 8`, `writeData = 0x2A`; `retired = 1`.
- Load byte signed, memData 0x12AB34CD, addrLow 2 -> `writeData = 0xFFFFFFAB`. Same with unsigned -> 0x000000AB. Half signed, addrLow 1 -> 0x000034CD.
- Write to reg 0 with valid -> `regWrite = 0`, `fwd0Valid = 0`, `retired` increments.
- Capture to reg 9, then `stall` for 3 cycles -> `regWrite` high only in first cycle; `fwd0Valid` high for all 4 cycles; `retired` +1 only.
- Writes to reg 10 (value 5) then reg 11 (value 7), back-to-back -> in the second cycle `fwd0 = {11, 7}`, `fwd1 = {10, 5}`. Without `MEM_WB_FORWARD_EN`, all `fwd*` = 0.
- `flush` asserted with a valid write to reg 12 pending -> bubble, no write. Then `reset` during a stalled slot -> all outputs 0, `retired = 0`.
